skewed_sync_pair: RTL

- Two-input unary/stochastic bitstream correlation manipulator, generalised from the single-sided skewed synchroniser.
- Each input gets its own saturating saved-bit counter of configurable depth.
- Runtime mode selects SYNC, which maximises 1-overlap (SCC toward +1), or DESYNC, which minimises 1-overlap (SCC toward -1).
- A flush input drains saved bits at stream end, so output 1-count equals input 1-count whenever no saturation occurred.
- Sits between stream generators and correlation-sensitive unary arithmetic (AND-multiply, OR/min/max).

---
 rtl/skewed_sync_pair_pkg.sv | 30 +++
 rtl/skewed_sync_pair_sat_bit_counter.sv | 39 +++
 rtl/skewed_sync_pair.sv | 124 ++++++++++++
 3 files changed

// File: rtl/skewed_sync_pair_pkg.sv
// Shared definitions for unary/stochastic stream correlation blocks:
// the sync mode encoding and a saturating up/down step helper.
package skewed_sync_pair_pkg;

  typedef enum logic {
    SYNC   = 1'b0,
    DESYNC = 1'b1
  } sync_mode_t;

  localparam int CNT_W_LIMIT = 8;

  // One saturating step on a counter of up to CNT_W_LIMIT bits; a
  // simultaneous inc and dec cancel, and the bounds are never crossed.
  function automatic logic [CNT_W_LIMIT-1:0] sat_step(
    input logic [CNT_W_LIMIT-1:0] cur,
    input logic [CNT_W_LIMIT-1:0] max_val,
    input logic                   inc,
    input logic                   dec
  );
    logic [CNT_W_LIMIT-1:0] res;
    res = cur;
    if (inc && !dec && (cur < max_val)) begin
      res = cur + 8'd1;
    end else if (dec && !inc && (cur != '0)) begin
      res = cur - 8'd1;
    end
    return res;
  endfunction

endpackage

// File: rtl/skewed_sync_pair_sat_bit_counter.sv
// DEP-wide up/down saturating counter holding the saved-1 count of one
// stream channel; DEP is limited to CNT_W_LIMIT bits.
module sat_bit_counter
  import skewed_sync_pair_pkg::*;
#(
  parameter int DEP = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           inc,
  input  logic           dec,
  output logic [DEP-1:0] cnt,
  output logic           full,
  output logic           empty
);

  localparam logic [DEP-1:0] MAX_CNT = {DEP{1'b1}};
  localparam logic [CNT_W_LIMIT-1:0] MAX_WIDE = CNT_W_LIMIT'(MAX_CNT);

  logic [DEP-1:0] cnt_reg;
  logic [DEP-1:0] cnt_next;

  always_comb begin
    cnt_next = DEP'(sat_step(CNT_W_LIMIT'(cnt_reg), MAX_WIDE, inc, dec));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_next;
    end
  end

  assign cnt   = cnt_reg;
  assign full  = (cnt_reg == MAX_CNT);
  assign empty = (cnt_reg == '0);

endmodule

// File: rtl/skewed_sync_pair.sv
// Two-channel skewed synchroniser: pulls a pair of unary bitstreams toward
// maximal (SYNC) or minimal (DESYNC) 1-overlap using per-channel saved-bit counters.
module skewed_sync_pair
  import skewed_sync_pair_pkg::*;
#(
  parameter int DEP = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  input  logic           mode,
  input  logic           flush,
  input  logic           in0,
  input  logic           in1,
  output logic           out0,
  output logic           out1,
  output logic [DEP-1:0] cnt0,
  output logic [DEP-1:0] cnt1,
  output logic           busy
);

  logic       inc0, dec0, inc1, dec1;
  logic       full0, empty0, full1, empty1;
  sync_mode_t mode_sel;

  assign mode_sel = sync_mode_t'(mode);

  sat_bit_counter #(.DEP(DEP)) u_cnt0 (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (inc0),
    .dec   (dec0),
    .cnt   (cnt0),
    .full  (full0),
    .empty (empty0)
  );

  sat_bit_counter #(.DEP(DEP)) u_cnt1 (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (inc1),
    .dec   (dec1),
    .cnt   (cnt1),
    .full  (full1),
    .empty (empty1)
  );

  always_comb begin
    out0 = 1'b0;
    out1 = 1'b0;
    inc0 = 1'b0;
    dec0 = 1'b0;
    inc1 = 1'b0;
    dec1 = 1'b0;
    if (!in_valid) begin
      // no stream bit: outputs silent, counters hold
    end else if (!rst_n) begin
      // Counters cannot capture while held in reset, so nothing is saved
      // and every bit passes straight through.
      out0 = in0;
      out1 = in1;
    end else if (flush) begin
      out0 = in0 | !empty0;
      out1 = in1 | !empty1;
      dec0 = !empty0 && !in0;
      dec1 = !empty1 && !in1;
    end else if (mode_sel == SYNC) begin
      if (in0 == in1) begin
        out0 = in0;
        out1 = in1;
      end else if (in0) begin
        // pair the lone 1 with a saved 1 of the other channel, else save it
        if (!empty1) begin
          out0 = 1'b1;
          out1 = 1'b1;
          dec1 = 1'b1;
        end else if (!full0) begin
          inc0 = 1'b1;
        end else begin
          out0 = 1'b1;
        end
      end else begin
        if (!empty0) begin
          out0 = 1'b1;
          out1 = 1'b1;
          dec0 = 1'b1;
        end else if (!full1) begin
          inc1 = 1'b1;
        end else begin
          out1 = 1'b1;
        end
      end
    end else begin
      if (in0 && in1) begin
        // split the overlapping pair, saving one of the two 1s
        if (!full1) begin
          out0 = 1'b1;
          inc1 = 1'b1;
        end else if (!full0) begin
          out1 = 1'b1;
          inc0 = 1'b1;
        end else begin
          out0 = 1'b1;
          out1 = 1'b1;
        end
      end else if (!in0 && !in1) begin
        // fill an idle slot from the larger saved count
        if ((cnt0 >= cnt1) && !empty0) begin
          out0 = 1'b1;
          dec0 = 1'b1;
        end else if (!empty1) begin
          out1 = 1'b1;
          dec1 = 1'b1;
        end
      end else begin
        out0 = in0;
        out1 = in1;
      end
    end
  end

  assign busy = !empty0 || !empty1;

endmodule
